// File: rtl/axis_counter_checker.sv
// AXI-Stream incrementing-counter checker: acquires lock on a +1 sequence in the
// low tdata bits, then counts and records mismatches while locked.
module axis_counter_checker #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_WIDTH    = 32,
    parameter int ERR_WIDTH        = 16,
    parameter int LOCK_THRESHOLD   = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    output logic                        locked,
    output logic [31:0]                 beat_count,
    output logic [ERR_WIDTH-1:0]        err_count,
    output logic [COUNTER_WIDTH-1:0]    last_bad,
    output logic [1:0]                  dbg_state
);

    // Handshake: a beat is accepted in any cycle where S_AXIS_tvalid and the
    // registered S_AXIS_tready are both high; tready depends only on state.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // run holds the seed beat plus correct beats, so it tops out at LOCK_THRESHOLD+1
    localparam int RUN_W = $clog2(LOCK_THRESHOLD + 2);

    state_t                     state_q, state_d;
    logic                       tready_q, tready_d;
    logic                       locked_q, locked_d;
    logic                       first_q, first_d;
    logic [RUN_W-1:0]           run_q, run_d;
    logic [COUNTER_WIDTH-1:0]   exp_q, exp_d;
    logic [31:0]                beat_count_q, beat_count_d;
    logic [ERR_WIDTH-1:0]       err_count_q, err_count_d;
    logic [COUNTER_WIDTH-1:0]   last_bad_q, last_bad_d;

    logic                       accept;
    logic                       match;
    logic [COUNTER_WIDTH-1:0]   cmp_data;
    logic                       unused_tdata;

    assign cmp_data     = S_AXIS_tdata[COUNTER_WIDTH-1:0];
    assign unused_tdata = ^S_AXIS_tdata;
    assign accept       = S_AXIS_tvalid && tready_q;
    assign match        = (cmp_data == exp_q);

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        run_d        = run_q;
        exp_d        = exp_q;
        beat_count_d = beat_count_q;
        err_count_d  = err_count_q;
        last_bad_d   = last_bad_q;

        if (accept) begin
            exp_d = cmp_data + COUNTER_WIDTH'(1);
            if (beat_count_q != '1) begin
                beat_count_d = beat_count_q + 32'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACQUIRE;
                    first_d = 1'b1;
                    run_d   = '0;
                end
            end
            ST_ACQUIRE: begin
                if (accept) begin
                    if (first_q) begin
                        // Seed beat: nothing to compare against yet
                        first_d = 1'b0;
                        run_d   = RUN_W'(1);
                    end else if (match) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_q >= RUN_W'(LOCK_THRESHOLD)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d = RUN_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (accept && !match) begin
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_WIDTH'(1);
                    end
                    last_bad_d = cmp_data;
                    run_d      = RUN_W'(1);
                    state_d    = ST_ACQUIRE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
        end

        if (clear) begin
            beat_count_d = '0;
            err_count_d  = '0;
            last_bad_d   = '0;
        end
    end

    // Outputs are registered off the next state so they line up with state_q
    always_comb begin
        tready_d = (state_d != ST_IDLE);
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            tready_q     <= 1'b0;
            locked_q     <= 1'b0;
            first_q      <= 1'b1;
            run_q        <= '0;
            exp_q        <= '0;
            beat_count_q <= '0;
            err_count_q  <= '0;
            last_bad_q   <= '0;
        end else begin
            state_q      <= state_d;
            tready_q     <= tready_d;
            locked_q     <= locked_d;
            first_q      <= first_d;
            run_q        <= run_d;
            exp_q        <= exp_d;
            beat_count_q <= beat_count_d;
            err_count_q  <= err_count_d;
            last_bad_q   <= last_bad_d;
        end
    end

    assign S_AXIS_tready = tready_q;
    assign locked        = locked_q;
    assign beat_count    = beat_count_q;
    assign err_count     = err_count_q;
    assign last_bad      = last_bad_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_counter_checker.sv
// Directed bench for axis_counter_checker: default, LOCK_THRESHOLD=1 and
// COUNTER_WIDTH=8 instances checked against hand-computed values.
module tb_axis_counter_checker;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn;
    logic        enable;
    logic        clear;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tready;
    logic        locked;
    logic [31:0] beat_count;
    logic [15:0] err_count;
    logic [31:0] last_bad;
    logic [1:0]  dbg_state;

    logic        t1_tready;
    logic        t1_locked;
    logic [31:0] t1_beat_count;
    logic [15:0] t1_err_count;
    logic [31:0] t1_last_bad;
    logic [1:0]  t1_dbg_state;

    logic        e8;
    logic        v8;
    logic [31:0] d8;
    logic        r8;
    logic        locked8;
    logic [31:0] beat8;
    logic [15:0] err8;
    logic [7:0]  bad8;
    logic [1:0]  state8;

    int n_checks = 0;
    int n_errors = 0;

    axis_counter_checker dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear(clear),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(tready),
        .locked(locked), .beat_count(beat_count), .err_count(err_count),
        .last_bad(last_bad), .dbg_state(dbg_state)
    );

    axis_counter_checker #(.LOCK_THRESHOLD(1)) dut_t1 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear(clear),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(t1_tready),
        .locked(t1_locked), .beat_count(t1_beat_count), .err_count(t1_err_count),
        .last_bad(t1_last_bad), .dbg_state(t1_dbg_state)
    );

    axis_counter_checker #(.COUNTER_WIDTH(8)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .enable(e8), .clear(1'b0),
        .S_AXIS_tvalid(v8), .S_AXIS_tdata(d8), .S_AXIS_tready(r8),
        .locked(locked8), .beat_count(beat8), .err_count(err8),
        .last_bad(bad8), .dbg_state(state8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        tvalid = 1'b1;
        tdata  = v;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nxt;
        logic [7:0]  seq8 [5];
        int          hs;

        aresetn = 1'b0; enable = 1'b0; clear = 1'b0; tvalid = 1'b0; tdata = '0;
        e8 = 1'b0; v8 = 1'b0; d8 = '0;
        tick();
        tick();
        chk("rst_tready", tready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_beat", beat_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_last_bad", last_bad, 0);
        chk("rst_state", dbg_state, 0);

        // Basic acquire and lock on 0,1,2,...
        aresetn = 1'b1; enable = 1'b1; tvalid = 1'b1; tdata = 32'd0;
        tick();
        chk("en_tready", tready, 1);
        chk("en_state", dbg_state, 1);
        send(32'd0);
        chk("t1_seed_locked", t1_locked, 0);
        send(32'd1);
        chk("t1_lock", t1_locked, 1);
        send(32'd2);
        send(32'd3);
        chk("pre_lock", locked, 0);
        send(32'd4);
        chk("lock_at_4", locked, 1);
        chk("lock_err", err_count, 0);
        chk("lock_beats", beat_count, 5);
        for (int v = 5; v < 12; v++) send(v);
        chk("still_locked", locked, 1);

        // Skip 12: one error, relock after 14..17
        send(32'd13);
        chk("miss_locked", locked, 0);
        chk("miss_err", err_count, 1);
        chk("miss_last_bad", last_bad, 13);
        send(32'd14);
        send(32'd15);
        send(32'd16);
        chk("relock_early", locked, 0);
        send(32'd17);
        chk("relock", locked, 1);
        chk("relock_err", err_count, 1);
        chk("relock_beats", beat_count, 17);

        // Random tvalid gaps on an increasing sequence
        nxt = 32'd18;
        hs  = 0;
        for (int i = 0; i < 30; i++) begin
            tvalid = 1'($urandom_range(0, 1));
            tdata  = nxt;
            tick();
            if (tvalid) begin
                nxt++;
                hs++;
            end
        end
        chk("gap_beats", beat_count, 32'(17 + hs));
        chk("gap_err", err_count, 1);
        chk("gap_locked", locked, 1);

        // Mismatch while locked together with clear
        tvalid = 1'b1; tdata = nxt + 5; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_err", err_count, 0);
        chk("clr_beats", beat_count, 0);
        chk("clr_last_bad", last_bad, 0);
        chk("clr_state", dbg_state, 1);
        send(nxt + 6);
        send(nxt + 7);
        send(nxt + 8);
        chk("clr_relock_early", locked, 0);
        send(nxt + 9);
        chk("clr_relock", locked, 1);

        // Drop enable while locked, restart at 500
        enable = 1'b0; tvalid = 1'b0;
        tick();
        chk("idle_tready", tready, 0);
        chk("idle_state", dbg_state, 0);
        chk("idle_locked", locked, 0);
        tick();
        chk("idle_tready2", tready, 0);
        chk("idle_beats_hold", beat_count, 4);
        enable = 1'b1;
        tick();
        chk("reen_tready", tready, 1);
        for (int v = 500; v < 504; v++) send(v);
        chk("new_seq_early", locked, 0);
        send(32'd504);
        chk("new_seq_lock", locked, 1);
        chk("new_seq_err", err_count, 0);
        chk("new_seq_beats", beat_count, 9);

        // 8-bit counter wrap with random upper bits
        tvalid = 1'b0;
        e8 = 1'b1;
        tick();
        v8 = 1'b1;
        seq8[0] = 8'hfd; seq8[1] = 8'hfe; seq8[2] = 8'hff; seq8[3] = 8'h00; seq8[4] = 8'h01;
        for (int i = 0; i < 5; i++) begin
            d8 = $urandom();
            d8[7:0] = seq8[i];
            tick();
            if (i == 3) chk("w8_pre_lock", locked8, 0);
        end
        v8 = 1'b0;
        chk("w8_lock", locked8, 1);
        chk("w8_err", err8, 0);
        chk("w8_beats", beat8, 5);

        // Reset in the middle of a stream
        tvalid = 1'b1; tdata = 32'd505; clear = 1'b0; aresetn = 1'b0;
        tick();
        chk("mid_rst_tready", tready, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_beats", beat_count, 0);
        chk("mid_rst_state", dbg_state, 0);
        chk("mid_rst_w8_beats", beat8, 0);
        aresetn = 1'b1;
        tick();
        for (int v = 700; v < 705; v++) send(v);
        chk("post_rst_lock", locked, 1);
        chk("post_rst_err", err_count, 0);
        chk("post_rst_beats", beat_count, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
